// File: rtl/store_rmw_unit_if.sv
// Store-unit bus: datapath store request/status plus the word-wide data-memory port.
interface store_rmw_unit_if;
  logic        st_req;
  logic [1:0]  st_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rd;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output st_req, st_type, addr, wdata, mem_rd,
    input  mem_addr, mem_we, mem_wd, busy, done, err
  );

  modport slave (
    input  st_req, st_type, addr, wdata, mem_rd,
    output mem_addr, mem_we, mem_wd, busy, done, err
  );
endinterface

// File: rtl/store_rmw_unit.sv
// Executes sb/sh/sw against a word-only data memory. Sub-word stores read the
// aligned word, merge the addressed lane and write the word back.
module store_rmw_unit (
  input  logic            clk,
  input  logic            rst,
  store_rmw_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  localparam logic [1:0] TYPE_SB = 2'd0;
  localparam logic [1:0] TYPE_SH = 2'd1;
  localparam logic [1:0] TYPE_SW = 2'd2;

  state_t      state;
  state_t      next_state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_q;
  logic [1:0]  type_q;
  logic        req_bad;
  logic [31:0] merged;

  // Reserved type or an address not aligned to the access size is rejected up front.
  always_comb begin
    req_bad = 1'b0;
    case (bus.st_type)
      TYPE_SB: req_bad = 1'b0;
      TYPE_SH: req_bad = bus.addr[0];
      TYPE_SW: req_bad = |bus.addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.st_req) begin
          if (req_bad) begin
            next_state = ERR;
          end else if (bus.st_type == TYPE_SW) begin
            next_state = WRITE;
          end else begin
            next_state = READ;
          end
        end
      end
      READ:    next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Only the latched request is used after acceptance, so the datapath may move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= '0;
      rd_q    <= '0;
    end else begin
      if (state == IDLE && bus.st_req) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        type_q  <= bus.st_type;
      end
      if (state == READ) begin
        rd_q <= bus.mem_rd;
      end
    end
  end

  // Little-endian lane merge; a word store ignores the read-back entirely.
  always_comb begin
    merged = rd_q;
    case (type_q)
      TYPE_SB: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      TYPE_SH: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    bus.busy   = (state != IDLE);
    bus.mem_we = (state == WRITE);
    bus.done   = (state == DONE) || (state == ERR);
    bus.err    = (state == ERR);
  end

  assign bus.mem_addr = {addr_q[31:2], 2'b00};
  assign bus.mem_wd   = merged;
endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: directed table, handshake/reset
// sequences and random stores against a byte-addressed reference memory.
module tb_store_rmw_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  store_rmw_unit_if bus ();

  store_rmw_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory driven by the DUT, plus a preload path for test setup.
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  assign bus.mem_rd = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wd;
    end
  end

  // Reference: plain byte-addressed memory updated by access size.
  logic [7:0] ref_bytes [0:1023];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int w;
    w = int'(a[9:0]) & ~3;
    return {ref_bytes[w + 3], ref_bytes[w + 2], ref_bytes[w + 1], ref_bytes[w]};
  endfunction

  task automatic ref_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                           output logic exp_err, output int exp_lat);
    int size;
    size    = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    exp_err = (t == 2'd3) || ((int'(a[9:0]) % size) != 0);
    if (exp_err) begin
      exp_lat = 1;
    end else begin
      for (int j = 0; j < size; j++) ref_bytes[int'(a[9:0]) + j] = d[8*j +: 8];
      exp_lat = (t == 2'd2) ? 2 : 3;
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = idx[7:0];
    pre_data = val;
    for (int j = 0; j < 4; j++) ref_bytes[idx*4 + j] = val[8*j +: 8];
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issues one store and watches it to completion, bounded at 10 cycles.
  task automatic apply_stimulus(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                output int lat, output int we_cnt, output logic got_err,
                                output logic addr_bad);
    @(negedge clk);
    bus.st_req  = 1'b1;
    bus.st_type = t;
    bus.addr    = a;
    bus.wdata   = d;
    @(negedge clk);
    bus.st_req  = 1'b0;
    bus.st_type = 2'($urandom);
    bus.addr    = $urandom;
    bus.wdata   = $urandom;
    lat      = 0;
    we_cnt   = 0;
    got_err  = 1'b0;
    addr_bad = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.mem_we) begin
        we_cnt++;
        if (bus.mem_addr !== {a[31:2], 2'b00}) addr_bad = 1'b1;
      end
      if (bus.done) begin
        lat     = c;
        got_err = bus.err;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_word;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lat;
    int          we_cnt;
    logic        got_err;
    logic        addr_bad;
    logic        e_err;
    int          e_lat;
    logic [7:0]  busy_h;
    logic [7:0]  done_h;
    logic [7:0]  we_h;
    logic [1:0]  rt;
    logic [31:0] ra;
    logic [31:0] rd;
    int          bad_words;

    checks = 0;
    errors = 0;
    vecs[0] = '{2'd0, 32'h101, 32'h00000012, 32'hdead12ef, 3, 1'b0};
    vecs[1] = '{2'd0, 32'h100, 32'h00000012, 32'hdead1212, 3, 1'b0};
    vecs[2] = '{2'd0, 32'h103, 32'h00000012, 32'h12ad1212, 3, 1'b0};
    vecs[3] = '{2'd1, 32'h106, 32'hffffbeef, 32'hbeefc0de, 3, 1'b0};
    vecs[4] = '{2'd1, 32'h104, 32'hffffbeef, 32'hbeefbeef, 3, 1'b0};
    vecs[5] = '{2'd2, 32'h108, 32'hc001c0de, 32'hc001c0de, 2, 1'b0};
    vecs[6] = '{2'd1, 32'h103, 32'h0000abcd, 32'h12ad1212, 1, 1'b1};
    vecs[7] = '{2'd2, 32'h10a, 32'h11223344, 32'hc001c0de, 1, 1'b1};
    vecs[8] = '{2'd3, 32'h100, 32'h55667788, 32'h12ad1212, 1, 1'b1};

    rst         = 1'b1;
    pre_we      = 1'b0;
    pre_idx     = '0;
    pre_data    = '0;
    bus.st_req  = 1'b0;
    bus.st_type = '0;
    bus.addr    = '0;
    bus.wdata   = '0;

    for (int i = 0; i < 256; i++) preload(i, $urandom);
    preload(32'h100 >> 2, 32'hdeadbeef);
    preload(32'h104 >> 2, 32'hdeadc0de);

    @(negedge clk);
    check_output("reset_status", {28'd0, bus.busy, bus.done, bus.err, bus.mem_we}, 32'd0);
    check_output("reset_mem_addr", bus.mem_addr, 32'd0);
    check_output("reset_mem_wd", bus.mem_wd, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      ref_store(vecs[i].t, vecs[i].a, vecs[i].d, e_err, e_lat);
      apply_stimulus(vecs[i].t, vecs[i].a, vecs[i].d, lat, we_cnt, got_err, addr_bad);
      check_output($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check_output($sformatf("vec%0d_err", i), {31'd0, got_err}, {31'd0, vecs[i].exp_err});
      check_output($sformatf("vec%0d_we_count", i), we_cnt, vecs[i].exp_err ? 0 : 1);
      check_output($sformatf("vec%0d_we_addr", i), {31'd0, addr_bad}, 32'd0);
      check_output($sformatf("vec%0d_word", i), mem[vecs[i].a[9:2]], vecs[i].exp_word);
    end

    // Request held high across an SB with wdata changing mid-operation.
    ref_store(2'd0, 32'h101, 32'h000000aa, e_err, e_lat);
    @(negedge clk);
    bus.st_req  = 1'b1;
    bus.st_type = 2'd0;
    bus.addr    = 32'h101;
    bus.wdata   = 32'h000000aa;
    busy_h = '0;
    done_h = '0;
    we_h   = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      busy_h[c] = bus.busy;
      done_h[c] = bus.done;
      we_h[c]   = bus.mem_we;
      if (c == 1) bus.wdata = 32'h00000055;
      if (c == 4) begin
        check_output("hs_first_word", mem[8'h40], ref_word(32'h101));
        ref_store(2'd0, 32'h101, 32'h00000055, e_err, e_lat);
      end
      if (c == 7) bus.st_req = 1'b0;
    end
    @(negedge clk);
    check_output("hs_busy_trace", {24'd0, busy_h}, 32'h000000ee);
    check_output("hs_done_trace", {24'd0, done_h}, 32'h00000088);
    check_output("hs_we_trace", {24'd0, we_h}, 32'h00000044);
    check_output("hs_second_word", mem[8'h40], ref_word(32'h101));

    // A request raised while READ is in progress must be ignored.
    ref_store(2'd0, 32'h102, 32'h00000033, e_err, e_lat);
    @(negedge clk);
    bus.st_req  = 1'b1;
    bus.st_type = 2'd0;
    bus.addr    = 32'h102;
    bus.wdata   = 32'h00000033;
    busy_h = '0;
    done_h = '0;
    we_h   = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      busy_h[c] = bus.busy;
      done_h[c] = bus.done;
      we_h[c]   = bus.mem_we;
      if (c == 1) begin
        bus.st_type = 2'd2;
        bus.addr    = 32'h100;
        bus.wdata   = 32'hbadbadba;
      end
      if (c == 2) bus.st_req = 1'b0;
    end
    check_output("pulse_busy_trace", {24'd0, busy_h}, 32'h0000000e);
    check_output("pulse_done_trace", {24'd0, done_h}, 32'h00000008);
    check_output("pulse_we_trace", {24'd0, we_h}, 32'h00000004);
    check_output("pulse_word", mem[8'h40], ref_word(32'h100));

    // Reset during READ aborts the store without any write or done.
    @(negedge clk);
    bus.st_req  = 1'b1;
    bus.st_type = 2'd0;
    bus.addr    = 32'h100;
    bus.wdata   = 32'h00000077;
    @(negedge clk);
    bus.st_req = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rstmid_status", {28'd0, bus.busy, bus.done, bus.err, bus.mem_we}, 32'd0);
    check_output("rstmid_mem_addr", bus.mem_addr, 32'd0);
    check_output("rstmid_mem_wd", bus.mem_wd, 32'd0);
    done_h = '0;
    we_h   = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      done_h[c] = bus.done;
      we_h[c]   = bus.mem_we;
    end
    check_output("rstmid_quiet", {16'd0, done_h, we_h}, 32'd0);
    check_output("rstmid_word", mem[8'h40], ref_word(32'h100));
    ref_store(2'd2, 32'h100, 32'h0badf00d, e_err, e_lat);
    apply_stimulus(2'd2, 32'h100, 32'h0badf00d, lat, we_cnt, got_err, addr_bad);
    check_output("rstmid_sw_latency", lat, 2);
    check_output("rstmid_sw_word", mem[8'h40], ref_word(32'h100));

    // Reset and request on the same edge: request dropped.
    @(negedge clk);
    rst         = 1'b1;
    bus.st_req  = 1'b1;
    bus.st_type = 2'd2;
    bus.addr    = 32'h100;
    bus.wdata   = 32'hffffffff;
    @(negedge clk);
    rst        = 1'b0;
    bus.st_req = 1'b0;
    check_output("rstreq_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_output("rstreq_word", mem[8'h40], ref_word(32'h100));

    // Random stores against the reference memory.
    for (int n = 0; n < 150; n++) begin
      rt = 2'($urandom_range(0, 3));
      ra = 32'h100 + $urandom_range(0, 63);
      rd = $urandom;
      ref_store(rt, ra, rd, e_err, e_lat);
      apply_stimulus(rt, ra, rd, lat, we_cnt, got_err, addr_bad);
      check_output($sformatf("rnd%0d_latency", n), lat, e_lat);
      check_output($sformatf("rnd%0d_err", n), {31'd0, got_err}, {31'd0, e_err});
      check_output($sformatf("rnd%0d_we_count", n), we_cnt, e_err ? 0 : 1);
      check_output($sformatf("rnd%0d_word", n), mem[ra[9:2]], ref_word(ra));
    end

    @(negedge clk);
    bad_words = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_word(32'(i * 4))) bad_words++;
    end
    check_output("mem_sweep_bad_words", bad_words, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
